// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Index counters never shrink below one bit, even for a single nibble.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/csa4_slice.sv
// Combinational 4-bit carry-select adder slice.
module csa4_slice
  import nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                carry_o
);

  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  assign lo  = {1'b0, a_i[1:0]} + {1'b0, b_i[1:0]} + {2'b00, cin_i};
  // Upper half precomputed for both possible carries, picked by the lower half.
  assign hi0 = {1'b0, a_i[3:2]} + {1'b0, b_i[3:2]};
  assign hi1 = hi0 + 3'd1;

  assign sum_o   = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
  assign carry_o = lo[2] ? hi1[2] : hi0[2];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit slice per clock, LSB nibble first.
// Optional two's-complement overflow output: define OVERFLOW_FLAG_EN.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
  input  logic                     op_cin,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] res_sum,
  output logic                     res_carry,
  output logic                     busy
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic                     res_ovf
`endif
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned IdxW = clog2_min1(NIBBLES);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    res_sum_q, res_sum_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            res_carry_q, res_carry_d;
  logic            start_ready_q, start_ready_d;
  logic            res_valid_q, res_valid_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;

  logic [IdxW+1:0]     base;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_carry;
  logic                last;

  assign base = {idx_q, 2'b00};
  assign last = (idx_q == IdxW'(NIBBLES - 1));

  csa4_slice u_slice (
    .a_i     (a_q[base +: NIBBLE_W]),
    .b_i     (b_q[base +: NIBBLE_W]),
    .cin_i   (carry_q),
    .sum_o   (slice_sum),
    .carry_o (slice_carry)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_sum_d   = res_sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    res_carry_d = res_carry_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d       = op_a;
          b_d       = op_b;
          carry_d   = op_cin;
          res_sum_d = '0;
          idx_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        res_sum_d[base +: NIBBLE_W] = slice_sum;
        carry_d = slice_carry;
        idx_d   = idx_q + 1'b1;
        if (last) begin
          res_carry_d = slice_carry;
          ovf_d       = (a_q[W-1] == b_q[W-1]) && (slice_sum[NIBBLE_W-1] != a_q[W-1]);
          state_d     = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    start_ready_d = (state_d == IDLE);
    res_valid_d   = (state_d == DONE);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      res_sum_q     <= '0;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      res_carry_q   <= 1'b0;
      ovf_q         <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_sum_q     <= res_sum_d;
      idx_q         <= idx_d;
      carry_q       <= carry_d;
      res_carry_q   <= res_carry_d;
      ovf_q         <= ovf_d;
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign res_sum     = res_sum_q;
  assign res_carry   = res_carry_q;
  assign busy        = busy_q;
`ifdef OVERFLOW_FLAG_EN
  assign res_ovf     = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4) against an arithmetic model.
module tb_nibble_serial_adder;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_cin = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_sum;
  logic         res_carry;
  logic         busy;
`ifdef OVERFLOW_FLAG_EN
  logic         res_ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_carry   (res_carry),
    .busy        (busy)
`ifdef OVERFLOW_FLAG_EN
    ,
    .res_ovf     (res_ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned addition, carry is bit W of the sum.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Drive a request at a negedge; returns at the negedge after the accepting posedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    @(negedge clk);
    op_a = a; op_b = b; op_cin = cin; start_valid = 1'b1;
    check("start_ready_idle", start_ready, 1);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  // Called in cycle n0 (accepting cycle = 0); scrambles inputs while waiting.
  task automatic collect(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int n0);
    logic [W:0] exp;
    int n;
    exp = model(a, b, cin);
    n = n0;
    while (!res_valid && n < 20) begin
      op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom);
      @(negedge clk);
      n++;
    end
    check("latency", n, NIBBLES + 1);
    check("busy_done", busy, 1);
    check("start_ready_done", start_ready, 0);
    check("res_sum", res_sum, exp[W-1:0]);
    check("res_carry", res_carry, exp[W]);
`ifdef OVERFLOW_FLAG_EN
    check("res_ovf", res_ovf, (a[W-1] == b[W-1]) && (exp[W-1] != a[W-1]));
`endif
  endtask

  task automatic release_done(input logic [W-1:0] held);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_drop", res_valid, 0);
    check("start_ready_back", start_ready, 1);
    check("busy_idle", busy, 0);
    check("res_sum_held_idle", res_sum, held);
  endtask

  task automatic full_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] exp;
    exp = model(a, b, cin);
    start_op(a, b, cin);
    collect(a, b, cin, 1);
    release_done(exp[W-1:0]);
  endtask

  initial begin
    logic [W-1:0] ra, rb, held;
    logic         rc;
    logic [W:0]   e;

    repeat (2) @(negedge clk);
    check("rst_start_ready", start_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_sum", res_sum, 0);
    check("rst_res_carry", res_carry, 0);
    check("rst_busy", busy, 0);
`ifdef OVERFLOW_FLAG_EN
    check("rst_res_ovf", res_ovf, 0);
`endif
    rst_n = 1'b1;

    full_op(16'h0000, 16'h0009, 1'b0);
    full_op(16'hFFFF, 16'h0000, 1'b1);
    full_op(16'h3333, 16'hCCCC, 1'b1);
    full_op(16'hFFFF, 16'hFFFF, 1'b1);
    full_op(16'h7FFF, 16'h0001, 1'b0);
    full_op(16'hFFFF, 16'h0001, 1'b0);
    full_op(16'h8000, 16'h8000, 1'b0);

    // Backpressure in DONE, then a start request that coincides with res_ready.
    start_op(16'hA5A5, 16'h1234, 1'b1);
    collect(16'hA5A5, 16'h1234, 1'b1, 1);
    held = res_sum;
    rc = res_carry;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_res_valid", res_valid, 1);
      check("bp_res_sum", res_sum, held);
      check("bp_res_carry", res_carry, rc);
      check("bp_start_ready", start_ready, 0);
    end
    op_a = 16'h0F0F; op_b = 16'h0101; op_cin = 1'b0;
    start_valid = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("coincident_not_accepted", busy, 0);
    check("coincident_idle_ready", start_ready, 1);
    @(negedge clk);
    start_valid = 1'b0;
    check("accepted_in_idle", busy, 1);
    collect(16'h0F0F, 16'h0101, 1'b0, 1);
    e = model(16'h0F0F, 16'h0101, 1'b0);
    release_done(e[W-1:0]);

    // Reset two cycles into RUN aborts with reset values.
    start_op(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_res_valid", res_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_res_sum", res_sum, 0);
    check("abort_start_ready", start_ready, 1);
    check("abort_res_carry", res_carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    full_op(16'h1234, 16'h4321, 1'b0);

    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      full_op(ra, rb, rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
